// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC engine.
//   crc_state_t      : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   CRC_DEFAULT_POLY : default generator polynomial x^3 + 1 (4'b1001)
// -----------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_t;

  localparam logic [3:0] CRC_DEFAULT_POLY = 4'b1001;

endpackage : crc_pkg

// File: rtl/crc_step.sv
// -----------------------------------------------------------------------------
// crc_step
// Combinational one-bit CRC remainder update (polynomial long division step).
//   rem      [CRC_W-1:0] in  : current remainder
//   bit_in              in  : next message / appended bit
//   poly_low [CRC_W-1:0] in : generator polynomial without its x^CRC_W term
//   rem_next [CRC_W-1:0] out: updated remainder
// -----------------------------------------------------------------------------
module crc_step #(
  parameter int CRC_W = 3
) (
  input  logic [CRC_W-1:0] rem,
  input  logic             bit_in,
  input  logic [CRC_W-1:0] poly_low,
  output logic [CRC_W-1:0] rem_next
);

  logic             fb;
  logic [CRC_W-1:0] shifted;

  // The bit leaving the top of the remainder decides whether the
  // polynomial is subtracted (XORed) this step.
  assign fb      = rem[CRC_W-1];
  assign shifted = {rem[CRC_W-2:0], bit_in};

  for (genvar gi = 0; gi < CRC_W; gi++) begin : g_bit
    assign rem_next[gi] = shifted[gi] ^ (fb & poly_low[gi]);
  end

endmodule : crc_step

// File: rtl/crc_serial_engine.sv
// -----------------------------------------------------------------------------
// crc_serial_engine
// Bit-serial CRC engine: shifts DATA_W message bits MSB-first followed by
// CRC_W appended bits through a one-bit-per-cycle division step.
//
// Optional build macro: CRC_SERIAL_ENGINE_CHECK_EN
//   When defined, the appended bits come from crc_in (check mode) and crc_ok
//   reports whether the final remainder is zero. Otherwise zeroes are
//   appended (generate mode) and crc_in/crc_ok do not exist.
//
// Ports
//   clk      in  1        rising-edge clock
//   rst      in  1        synchronous active-high reset
//   start    in  1        request a new computation (IDLE or DONE only)
//   poly     in  CRC_W+1  generator polynomial, MSB = x^CRC_W term (unused)
//   data_in  in  DATA_W   message, MSB first
//   crc_in   in  CRC_W    received CRC (check build only)
//   crc_ok   out 1        final remainder is zero (check build only)
//   busy     out 1        high while shifting
//   done     out 1        one-cycle completion pulse
//   crc_out  out CRC_W    final remainder, held until the next completion
// -----------------------------------------------------------------------------
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CRC_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CRC_W:0]    poly,
  input  logic [DATA_W-1:0] data_in,
`ifdef CRC_SERIAL_ENGINE_CHECK_EN
  input  logic [CRC_W-1:0]  crc_in,
  output logic              crc_ok,
`endif
  output logic              busy,
  output logic              done,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int TOT_W = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(TOT_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOT_W - 1);

  crc_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CRC_W-1:0] rem_reg;
  logic [CRC_W-1:0] rem_step;
  logic [CRC_W-1:0] poly_reg;
  logic [TOT_W-1:0] shift_reg;
  logic [CRC_W-1:0] crc_out_reg;
  logic [CRC_W-1:0] append_bits;
  logic             accept;
  logic             last_bit;

  // The x^CRC_W coefficient is implied by the division and never examined.
  logic unused_poly_msb;
  assign unused_poly_msb = poly[CRC_W];

`ifdef CRC_SERIAL_ENGINE_CHECK_EN
  logic crc_ok_reg;
  assign append_bits = crc_in;
  assign crc_ok      = crc_ok_reg;
`else
  assign append_bits = '0;
`endif

  assign accept   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last_bit = (cnt_reg == LAST_CNT);

  crc_step #(
    .CRC_W(CRC_W)
  ) u_step (
    .rem      (rem_reg),
    .bit_in   (shift_reg[TOT_W-1]),
    .poly_low (poly_reg),
    .rem_next (rem_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath. The message and appended bits are packed into one shift
  // register at acceptance so the step always consumes its MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      rem_reg     <= '0;
      poly_reg    <= '0;
      shift_reg   <= '0;
      crc_out_reg <= '0;
`ifdef CRC_SERIAL_ENGINE_CHECK_EN
      crc_ok_reg  <= 1'b0;
`endif
    end else if (accept) begin
      poly_reg  <= poly[CRC_W-1:0];
      shift_reg <= {data_in, append_bits};
      rem_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == ST_SHIFT) begin
      rem_reg   <= rem_step;
      shift_reg <= {shift_reg[TOT_W-2:0], 1'b0};
      cnt_reg   <= cnt_reg + 1'b1;
      // The result register is written on the edge entering DONE so that
      // crc_out (and crc_ok) are already valid while done is high.
      if (last_bit) begin
        crc_out_reg <= rem_step;
`ifdef CRC_SERIAL_ENGINE_CHECK_EN
        crc_ok_reg  <= (rem_step == '0);
`endif
      end
    end
  end

  assign busy    = (state_reg == ST_SHIFT);
  assign done    = (state_reg == ST_DONE);
  assign crc_out = crc_out_reg;

endmodule : crc_serial_engine
